seg7_scroll_scan: RTL

Message buffer, scroll engine and digit scanner for the 8-digit seven-segment display. Holds up to 16 five-bit letter codes (`LETTER_*` values from params.v), scrolls the message right-to-left across the display, and time-multiplexes the digits. It sits directly upstream of the letter-to-segment decoder:

- oLetter drives the decoder's iData.
- oAn drives the digit anodes.

---
 rtl/seg7_scroll_scan.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scroll_scan.sv
// seg7_scroll_scan: message buffer, scroll engine and digit scanner
// for an 8-digit seven-segment display.
//
// Ports:
//   iClk     system clock, rising edge
//   iRst     asynchronous active-high reset
//   iWrEn    write strobe for one buffer character
//   iWrAddr  buffer position 0..15
//   iWrData  letter code to store
//   iLoad    pulse: latch iLen and restart scrolling
//   iLen     message length, clamped to 16
//   iPause   level: freeze scrolling while high
//   oLetter  letter code for the scanned digit (5'h1F = blank)
//   oAn      active-low one-hot digit enables, bit 0 = leftmost
//   oStep    one-cycle pulse per scroll advance
//   oWrap    one-cycle pulse when the offset returns to 0
//
// Build option: define SEG_SCROLL_EN to build the scroll engine;
// without it the first 8 characters are shown statically.

module seg7_scroll_scan #(
    parameter int SCAN_DIV   = 100_000,
    parameter int SCROLL_DIV = 50_000_000
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iWrEn,
    input  logic [3:0] iWrAddr,
    input  logic [4:0] iWrData,
    input  logic       iLoad,
    input  logic [4:0] iLen,
    input  logic       iPause,
    output logic [4:0] oLetter,
    output logic [7:0] oAn,
    output logic       oStep,
    output logic       oWrap
);

    localparam logic [4:0] BLANK = 5'h1F;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic [4:0]        msg_q [16];
    logic [4:0]        len_q;
    logic [4:0]        len_in;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [2:0]        digit_q;
    logic [SCAN_W-1:0] scan_cnt;
    logic [4:0]        offset_q;
    logic [4:0]        pos;
    logic [4:0]        letter_d;
    logic              pause_eff;

    assign len_in = (iLen > 5'd16) ? 5'd16 : iLen;

    // Message buffer: writes land in every state.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < 16; i++) begin
                msg_q[i] <= BLANK;
            end
        end else if (iWrEn) begin
            msg_q[iWrAddr] <= iWrData;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            len_q <= 5'd0;
        end else if (iLoad) begin
            len_q <= len_in;
        end
    end

`ifdef SEG_SCROLL_EN
    assign pause_eff = iPause;
`else
    assign pause_eff = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (iLoad) begin
            if (len_in == 5'd0) begin
                state_d = ST_IDLE;
            end else if (state_q == ST_IDLE) begin
                state_d = ST_RUN;
            end else begin
                state_d = pause_eff ? ST_HOLD : ST_RUN;
            end
        end else begin
            case (state_q)
                ST_RUN:  if (pause_eff) state_d = ST_HOLD;
                ST_HOLD: if (!pause_eff) state_d = ST_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Digit scanner; parked on digit 0 while idle so a fresh
    // load always starts from the leftmost digit.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            scan_cnt <= '0;
            digit_q  <= 3'd0;
        end else if (state_q == ST_IDLE) begin
            scan_cnt <= '0;
            digit_q  <= 3'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            digit_q  <= digit_q + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

`ifdef SEG_SCROLL_EN
    localparam int SCR_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [SCR_W-1:0] SCR_LAST = SCR_W'(SCROLL_DIV - 1);

    logic [SCR_W-1:0] scroll_cnt;
    logic             scroll_tick;
    logic             wrap_hit;

    assign scroll_tick = (state_q == ST_RUN) && (scroll_cnt == SCR_LAST);
    // Message plus 8 trailing blanks: last offset is len + 7.
    assign wrap_hit    = (offset_q == len_q + 5'd7);

    // A load in the same cycle as a tick wins: restart, no step.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            scroll_cnt <= '0;
            offset_q   <= 5'd0;
            oStep      <= 1'b0;
            oWrap      <= 1'b0;
        end else begin
            oStep <= 1'b0;
            oWrap <= 1'b0;
            if (iLoad) begin
                scroll_cnt <= '0;
                offset_q   <= 5'd0;
            end else if (state_q == ST_IDLE) begin
                scroll_cnt <= '0;
            end else if (scroll_tick) begin
                scroll_cnt <= '0;
                oStep      <= 1'b1;
                if (wrap_hit) begin
                    offset_q <= 5'd0;
                    oWrap    <= 1'b1;
                end else begin
                    offset_q <= offset_q + 5'd1;
                end
            end else if (state_q == ST_RUN) begin
                scroll_cnt <= scroll_cnt + 1'b1;
            end
        end
    end
`else
    // Without scrolling the pause input and scroll rate have no role.
    logic unused_cfg;
    assign unused_cfg = iPause | (SCROLL_DIV < 1);

    assign offset_q = 5'd0;
    assign oStep    = 1'b0;
    assign oWrap    = 1'b0;
`endif

    // pos stays below 31 so 5 bits never overflow; pos < len <= 16
    // guarantees the low 4 bits index a valid buffer entry.
    assign pos      = offset_q + {2'b00, digit_q};
    assign letter_d = (pos < len_q) ? msg_q[pos[3:0]] : BLANK;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oAn     <= 8'hFF;
            oLetter <= BLANK;
        end else if (state_q == ST_IDLE) begin
            oAn     <= 8'hFF;
            oLetter <= BLANK;
        end else begin
            oAn     <= ~(8'b1 << digit_q);
            oLetter <= letter_d;
        end
    end

endmodule
